dii_packet_tx: RTL and testbench



---
 rtl/dii_packet_tx.sv | 137 +++++++++++++
 tb/tb_dii_packet_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dii_packet_tx.sv
// DII transmit packetizer: three header flits plus a counted payload, registered flit output.
// Optional length checking against pl_last is enabled by DII_PACKET_TX_LEN_CHECK_EN.
package dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module dii_packet_tx #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned PLEN_W  = $clog2(MAX_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_dest,
  input  logic [15:0]       req_src,
  input  logic [1:0]        req_type,
  input  logic [3:0]        req_type_sub,
  input  logic [PLEN_W-1:0] req_plen,
  input  logic [15:0]       pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              pl_last,
  output dii_pkg::dii_flit  flit_out,
  input  logic              flit_out_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, HDR_DEST, HDR_SRC, HDR_TYPE, PAYLOAD} state_t;

  localparam logic [PLEN_W-1:0] PLEN_MAX = PLEN_W'(MAX_LEN - 3);
  localparam logic [PLEN_W-1:0] ONE      = PLEN_W'(1);

  state_t              state, state_d;
  dii_pkg::dii_flit    flit_d;
  logic [PLEN_W-1:0]   cnt, cnt_d;
  logic [PLEN_W-1:0]   plen_q, plen_eff;
  logic [15:0]         dest_q, src_q;
  logic [5:0]          type_q;
  logic                armed;
  logic                load, req_fire, pl_fire, plen_sat;

  // armed keeps req_ready low while reset is asserted and on the first cycle after
  assign load      = !flit_out.valid || flit_out_ready;
  assign req_ready = (state == IDLE) && load && armed;
  assign pl_ready  = (state == PAYLOAD) && load;
  assign req_fire  = req_valid && req_ready;
  assign pl_fire   = pl_valid && pl_ready;
  assign plen_sat  = req_plen > PLEN_MAX;
  assign plen_eff  = plen_sat ? PLEN_MAX : req_plen;
  assign busy      = (state != IDLE) || flit_out.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      flit_out <= '0;
      cnt      <= '0;
      plen_q   <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      type_q   <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_d;
      flit_out <= flit_d;
      cnt      <= cnt_d;
      armed    <= 1'b1;
      if (req_fire) begin
        dest_q <= req_dest;
        src_q  <= req_src;
        type_q <= {req_type, req_type_sub};
        plen_q <= plen_eff;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    // a loadable register with nothing to send empties itself
    flit_d  = load ? '0 : flit_out;
    case (state)
      IDLE: begin
        if (req_fire) state_d = HDR_DEST;
      end
      HDR_DEST: begin
        if (load) begin
          flit_d  = '{valid: 1'b1, last: 1'b0, data: dest_q};
          state_d = HDR_SRC;
        end
      end
      HDR_SRC: begin
        if (load) begin
          flit_d  = '{valid: 1'b1, last: 1'b0, data: src_q};
          state_d = HDR_TYPE;
        end
      end
      HDR_TYPE: begin
        if (load) begin
          flit_d  = '{valid: 1'b1, last: (plen_q == '0), data: {type_q, 10'b0}};
          cnt_d   = plen_q;
          state_d = (plen_q == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pl_fire) begin
          flit_d = '{valid: 1'b1, last: (cnt == ONE), data: pl_data};
          cnt_d  = cnt - ONE;
          if (cnt == ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DII_PACKET_TX_LEN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (req_fire) begin
      err <= plen_sat;
    end else if (pl_fire && (pl_last != (cnt == ONE))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_pl_last;
  assign unused_pl_last = pl_last;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_dii_packet_tx.sv
// Self-checking bench for dii_packet_tx: vector table of packet requests, flit scoreboard,
// stall and mid-packet reset sequences.
module tb_dii_packet_tx;

`ifdef DII_PACKET_TX_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif
  localparam int MAXP = 5;

  typedef struct {
    logic [15:0] dest;
    logic [15:0] src;
    logic [1:0]  typ;
    logic [3:0]  sub;
    logic [3:0]  plen;
    logic [15:0] base;
    int          nwords;
    int          last_at;
    bit          exp_err;
    bit          stall;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [15:0] req_dest = '0, req_src = '0;
  logic [1:0] req_type = '0;
  logic [3:0] req_type_sub = '0, req_plen = '0;
  logic [15:0] pl_data;
  logic pl_valid, pl_ready, pl_last;
  dii_pkg::dii_flit flit_out;
  logic flit_out_ready;
  logic busy, err;

  dii_packet_tx #(.MAX_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_src(req_src),
    .req_type(req_type), .req_type_sub(req_type_sub), .req_plen(req_plen),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_last(pl_last),
    .flit_out(flit_out), .flit_out_ready(flit_out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] exp_q[$];
  logic [16:0] pl_q[$];
  int mon_cnt = 0, first_cyc = 0, last_cyc = 0;
  bit saw_plr = 0, stall_arm = 0, prev_stall = 0;
  int pat_i = 0;
  logic [3:0] pat = 4'b1001;
  dii_pkg::dii_flit prev_flit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // payload source: pops a word when the previous cycle fired
  initial begin
    bit pfire;
    pl_valid = 1'b0; pl_data = '0; pl_last = 1'b0;
    forever begin
      @(negedge clk);
      pfire = pl_valid && pl_ready && rst_n;
      @(posedge clk); #1;
      if (pfire && pl_q.size() > 0) void'(pl_q.pop_front());
      if (pl_q.size() > 0) begin
        pl_valid = 1'b1;
        {pl_last, pl_data} = pl_q[0];
      end else begin
        pl_valid = 1'b0;
      end
    end
  end

  // downstream ready: pattern 1,0,0,1 applied once payload starts on stall packets
  initial begin
    flit_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_arm && mon_cnt >= 3 && pat_i < 4) begin
        flit_out_ready = pat[3 - pat_i];
        pat_i++;
      end else begin
        flit_out_ready = 1'b1;
      end
    end
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_hold", 32'(flit_out), 32'(prev_flit));
      if (flit_out.valid && !flit_out_ready) chk("stall_pl_ready", 32'(pl_ready), 32'd0);
      if (pl_ready) saw_plr = 1;
      if (flit_out.valid && flit_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", {15'd0, flit_out.last, flit_out.data}, 32'h1ffff);
        end else begin
          chk("flit", {15'd0, flit_out.last, flit_out.data}, {15'd0, exp_q.pop_front()});
        end
        if (mon_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        mon_cnt++;
      end
      prev_stall = flit_out.valid && !flit_out_ready;
      prev_flit  = flit_out;
    end
  end

  function automatic int eff_of(input vec_t v);
    return (int'(v.plen) > MAXP) ? MAXP : int'(v.plen);
  endfunction

  task automatic setup(input vec_t v);
    int eff = eff_of(v);
    exp_q.delete();
    exp_q.push_back({1'b0, v.dest});
    exp_q.push_back({1'b0, v.src});
    exp_q.push_back({(eff == 0), v.typ, v.sub, 10'b0});
    for (int i = 0; i < eff; i++) exp_q.push_back({(i == eff - 1), v.base + 16'(i) * 16'h1111});
    for (int i = 0; i < v.nwords; i++) pl_q.push_back({(i + 1 == v.last_at), v.base + 16'(i) * 16'h1111});
    mon_cnt = 0; saw_plr = 0; pat_i = 0; stall_arm = v.stall;
  endtask

  task automatic request(input vec_t v, output bit acc);
    int t = 0;
    acc = 0;
    req_valid = 1'b1; req_dest = v.dest; req_src = v.src;
    req_type = v.typ; req_type_sub = v.sub; req_plen = v.plen;
    while (!acc && t < 50) begin
      @(negedge clk);
      if (req_ready) acc = 1;
      @(posedge clk); #1;
      t++;
    end
    req_valid = 1'b0;
    if (!acc) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pkt(input vec_t v);
    bit acc;
    int t = 0;
    int eff = eff_of(v);
    setup(v);
    request(v, acc);
    if (acc) begin
      chk("accept_lat0_valid", 32'(flit_out.valid), 32'd0);
      chk("accept_err", 32'(err), 32'(LEN_CHK && (int'(v.plen) > MAXP)));
      @(posedge clk); #1;
      chk("accept_lat1", {15'd0, flit_out.valid, flit_out.data}, {15'd0, 1'b1, v.dest});
      while (exp_q.size() > 0 && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (exp_q.size() > 0) chk("pkt_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      chk("flit_count", 32'(mon_cnt), 32'(3 + eff));
      chk("words_left", 32'(pl_q.size()), 32'(v.nwords - eff));
      chk("pl_ready_seen", 32'(saw_plr), 32'(eff > 0));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("err_final", 32'(err), 32'(LEN_CHK && v.exp_err));
      if (!v.stall) chk("back_to_back", 32'(last_cyc - first_cyc), 32'(2 + eff));
    end
    pl_q.delete();
    stall_arm = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit acc;
    int t;
    vecs[0] = '{16'h0001, 16'h0010, 2'd2, 4'd3, 4'd2, 16'hAAAA, 2, 2, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h5678, 2'd1, 4'hF, 4'd0, 16'h0000, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{16'h0A0A, 16'h0B0B, 2'd3, 4'd5, 4'd3, 16'h1000, 3, 2, 1'b1, 1'b0};
    vecs[3] = '{16'h0C0C, 16'h0D0D, 2'd0, 4'd1, 4'd1, 16'h2000, 1, 1, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h8000, 2'd2, 4'd9, 4'd9, 16'h3000, 9, 9, 1'b1, 1'b0};
    vecs[5] = '{16'h4321, 16'h8765, 2'd1, 4'd2, 4'd5, 16'h4000, 5, 5, 1'b0, 1'b0};
    vecs[6] = '{16'h5555, 16'h6666, 2'd3, 4'd7, 4'd4, 16'h5000, 4, 4, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_flit", 32'(flit_out), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_pl_ready", 32'(pl_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_pkt(vecs[i]);

    // reset while two payload words remain outstanding
    v = '{16'h7777, 16'h8888, 2'd1, 4'd1, 4'd4, 16'h6000, 4, 4, 1'b0, 1'b0};
    setup(v);
    request(v, acc);
    t = 0;
    while (!(flit_out.valid && flit_out.data == 16'h7111) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_pkt_reached", 32'(flit_out.data), 32'h7111);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flit", 32'(flit_out), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_pl_ready", 32'(pl_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    exp_q.delete();
    pl_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_pkt('{16'h9999, 16'hABCD, 2'd2, 4'd3, 4'd2, 16'h7000, 2, 2, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
